data_bus_fabric: RTL
====================

Name: data_bus_fabric

Overview:
Parametrised successor to the single-master address decoder and read mux in the top-level SoC. Decodes one CPU data-bus master onto SLAVE_CNT memory-mapped slaves (RAM, GPIO, future timers/UART), each with its own base/mask window. Adds what a plain combinational decoder lacks: a registered req/ready handshake with slave wait states, a timeout, error responses for unmapped or hung accesses, and a saturating error counter.

Parameters:
SLAVE_CNT, 4, number of slave ports (1..16)
SLAVE_BASE, {32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000} flattened (slot 0 in LSBs), SLAVE_CNT*32 bits, window base per slave
SLAVE_MASK, {4{32'hFFFF_F000}} flattened, SLAVE_CNT*32 bits, address bits compared per slave
TIMEOUT, 15, ACCESS cycles allowed before abort (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
m_req  in  1  master request, held until m_ready
m_we  in  1  master write enable
m_addr  in  32  master byte address
m_wdata  in  32  master write data
m_wmask  in  4  byte write mask
m_rdata  out  32  read data, valid while m_ready=1
m_ready  out  1  one-cycle completion pulse
m_err  out  1  error flag, valid while m_ready=1
s_sel  out  SLAVE_CNT  one-hot slave select
s_we  out  SLAVE_CNT  per-slave write enable (subset of s_sel)
s_addr  out  32  latched address, shared by all slaves
s_wdata  out  32  latched write data, shared
s_wmask  out  4  latched mask, shared
s_rdata  in  SLAVE_CNT*32  per-slave read data, flattened
s_ready  in  SLAVE_CNT  per-slave completion
err_cnt  out  8  saturating count of error responses

Behaviour:
- Reset: state IDLE; m_ready, m_err, s_sel, s_we, err_cnt = 0; m_rdata, s_addr, s_wdata, s_wmask = 0; timeout counter = 0. Reset mid-transaction aborts silently, no m_ready.
- Decode (IDLE only): hit[i] = ((m_addr & MASK[i]) == BASE[i]). Overlapping windows: lowest index wins.
- FSM IDLE: if m_req, latch addr/wdata/wmask/we/index; hit -> ACCESS, no hit -> RESP with err=1, rdata=0.
- ACCESS: s_sel[idx]=1, s_we[idx]=latched we; counter increments each cycle. If s_ready[idx]=1: capture s_rdata[idx] (writes capture 0), err=0 -> RESP. Else if counter==TIMEOUT-1: err=1, rdata=0 -> RESP. s_ready wins over timeout in the same cycle. s_ready of unselected slaves ignored.
- RESP: s_sel/s_we = 0; m_ready=1 for exactly one cycle with registered m_rdata/m_err; err_cnt += m_err, saturating at 255; -> IDLE.
- Latency: zero-wait slave = request accepted cycle 0, s_sel cycle 1, m_ready cycle 2. Unmapped = m_ready cycle 1. Timeout = m_ready cycle TIMEOUT+1.
- m_req sampled only in IDLE; changes to master inputs after acceptance are ignored. Back-to-back: new request may be accepted in the IDLE cycle after RESP (one request per 3 cycles minimum).
- Slaves commit writes in the cycle they assert s_ready with s_we set; aborted writes must not commit.

Decomposition:
- Shared package/header (alongside src/constants.vh): state encodings (IDLE/ACCESS/RESP), default memory-map base/mask constants, DATA_W = 32.
- One sub-module: bus_addr_match (combinational priority decode: m_addr, BASE, MASK -> hit, one-hot, index). FSM, latches and counters stay in data_bus_fabric.

Test Plan:
- Read slot 1 at 0x1004, s_ready[1] high in first ACCESS cycle, s_rdata slot1 = 0xDEADBEEF -> m_ready on cycle 2, m_rdata = 0xDEADBEEF, m_err = 0, s_sel = 4'b0010 for exactly one cycle.
- Write 0x2010, wdata 0x12345678, mask 4'b0011, slave 2 ready after 3 wait cycles -> s_we[2] held 4 cycles, s_addr/s_wdata/s_wmask stable, m_ready on cycle 5, err = 0.
- Access 0x8000_0000 (unmapped) -> m_ready on cycle 1, m_err = 1, m_rdata = 0, s_sel never asserted, err_cnt = 1.
- Slot 3 never ready, TIMEOUT = 15 -> s_sel[3] high 15 cycles, m_ready on cycle 16 with m_err = 1; ready on cycle 15 of ACCESS instead -> m_err = 0.
- 300 unmapped accesses -> err_cnt saturates at 255.
- Reset asserted during ACCESS -> next cycle all outputs 0, no m_ready; following read of 0x0000 completes normally.

Source files
------------

// File: rtl/data_bus_fabric_pkg.sv
// Shared definitions for the data bus fabric: bus width, FSM encoding and
// the default SoC memory map (RAM, GPIO, two spare 4 KiB windows).
package data_bus_fabric_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } bus_state_t;

   localparam logic [4*32-1:0] DEFAULT_BASE = {32'h0000_3000, 32'h0000_2000,
                                               32'h0000_1000, 32'h0000_0000};
   localparam logic [4*32-1:0] DEFAULT_MASK = {4{32'hFFFF_F000}};

endpackage

// File: rtl/data_bus_fabric_bus_addr_match.sv
// Combinational base/mask window decode; with overlapping windows the lowest
// slave index takes the access.
module bus_addr_match
   import data_bus_fabric_pkg::*;
#(
   parameter int                      SLAVE_CNT = 4,
   parameter logic [SLAVE_CNT*32-1:0] BASE      = DEFAULT_BASE,
   parameter logic [SLAVE_CNT*32-1:0] MASK      = DEFAULT_MASK
) (
   input  logic [DATA_W-1:0]    addr,
   output logic                 hit,
   output logic [SLAVE_CNT-1:0] onehot,
   output logic [3:0]           idx
);

   logic match_s;

   // Scan from the highest slot down so the lowest matching slot is kept last.
   always_comb begin
      hit     = 1'b0;
      onehot  = '0;
      idx     = 4'd0;
      match_s = 1'b0;
      for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
         match_s = ((addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32]);
         hit     = hit | match_s;
         idx     = match_s ? 4'(i) : idx;
         onehot  = match_s ? (SLAVE_CNT'(1) << i) : onehot;
      end
   end

endmodule

// File: rtl/data_bus_fabric.sv
// Single-master data bus fabric: decodes one request onto SLAVE_CNT windows,
// waits for the slave with a timeout and returns a one-cycle registered response.
module data_bus_fabric
   import data_bus_fabric_pkg::*;
#(
   parameter int                      SLAVE_CNT  = 4,
   parameter logic [SLAVE_CNT*32-1:0] SLAVE_BASE = DEFAULT_BASE,
   parameter logic [SLAVE_CNT*32-1:0] SLAVE_MASK = DEFAULT_MASK,
   parameter int                      TIMEOUT    = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        m_req,
   input  logic                        m_we,
   input  logic [DATA_W-1:0]           m_addr,
   input  logic [DATA_W-1:0]           m_wdata,
   input  logic [3:0]                  m_wmask,
   output logic [DATA_W-1:0]           m_rdata,
   output logic                        m_ready,
   output logic                        m_err,
   output logic [SLAVE_CNT-1:0]        s_sel,
   output logic [SLAVE_CNT-1:0]        s_we,
   output logic [DATA_W-1:0]           s_addr,
   output logic [DATA_W-1:0]           s_wdata,
   output logic [3:0]                  s_wmask,
   input  logic [SLAVE_CNT*DATA_W-1:0] s_rdata,
   input  logic [SLAVE_CNT-1:0]        s_ready,
   output logic [7:0]                  err_cnt
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   bus_state_t             state_r;
   logic [3:0]             idx_r;
   logic                   we_r;
   logic [7:0]             cnt_r;

   logic                   dec_hit_s;
   logic [SLAVE_CNT-1:0]   dec_onehot_s;
   logic [3:0]             dec_idx_s;
   logic                   sel_ready_s;
   logic [DATA_W-1:0]      sel_rdata_s;

   bus_addr_match #(
      .SLAVE_CNT (SLAVE_CNT),
      .BASE      (SLAVE_BASE),
      .MASK      (SLAVE_MASK)
   ) u_match (
      .addr   (m_addr),
      .hit    (dec_hit_s),
      .onehot (dec_onehot_s),
      .idx    (dec_idx_s)
   );

   // Only the latched slave's ready/rdata are visible; all other slots are masked off.
   always_comb begin
      sel_ready_s = 1'b0;
      sel_rdata_s = '0;
      for (int i = 0; i < SLAVE_CNT; i++) begin
         sel_ready_s = sel_ready_s | (s_ready[i] & (idx_r == 4'(i)));
         sel_rdata_s = sel_rdata_s | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{idx_r == 4'(i)}});
      end
   end

   // Transaction FSM with registered slave-side and master-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         idx_r   <= 4'd0;
         we_r    <= 1'b0;
         cnt_r   <= 8'd0;
         m_rdata <= '0;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         s_sel   <= '0;
         s_we    <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_wmask <= 4'd0;
         err_cnt <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               m_ready <= 1'b0;
               m_err   <= 1'b0;
               m_rdata <= '0;
               if (m_req) begin
                  s_addr  <= m_addr;
                  s_wdata <= m_wdata;
                  s_wmask <= m_wmask;
                  we_r    <= m_we;
                  idx_r   <= dec_idx_s;
                  cnt_r   <= 8'd0;
                  if (dec_hit_s) begin
                     s_sel   <= dec_onehot_s;
                     s_we    <= m_we ? dec_onehot_s : '0;
                     state_r <= ST_ACCESS;
                  end else begin
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     state_r <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               cnt_r <= cnt_r + 8'd1;
               // A slave answering on the last allowed cycle still wins over the timeout.
               if (sel_ready_s) begin
                  m_rdata <= we_r ? '0 : sel_rdata_s;
                  m_err   <= 1'b0;
                  m_ready <= 1'b1;
                  s_sel   <= '0;
                  s_we    <= '0;
                  state_r <= ST_RESP;
               end else if (cnt_r == TIMEOUT_LAST) begin
                  m_rdata <= '0;
                  m_err   <= 1'b1;
                  m_ready <= 1'b1;
                  s_sel   <= '0;
                  s_we    <= '0;
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               m_ready <= 1'b0;
               m_err   <= 1'b0;
               m_rdata <= '0;
               if (m_err && (err_cnt != 8'hFF)) begin
                  err_cnt <= err_cnt + 8'd1;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               m_ready <= 1'b0;
               m_err   <= 1'b0;
               s_sel   <= '0;
               s_we    <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
